// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and load write-backs into one register-file write port
// through a small FIFO, with loads taking priority and a decode hazard lookup.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_addr,
  input  logic [DW-1:0]            alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_data,
  output logic                     mem_ready,
  output logic                     wre,
  output logic [AW-1:0]            a3,
  output logic [DW-1:0]            wd3,
  input  logic [AW-1:0]            q_addr,
  output logic                     q_pending,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, wr_alu;
  logic [CW-1:0] count_q, count_d;
  logic          wre_q, wre_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic          push_m, push_a, pop;

  // Readiness looks only at registered occupancy; a same-edge pop frees its slot next cycle.
  assign mem_ready = rst && (count_q < FULL);
  assign alu_ready = rst && ((count_q <= FULL - CW'(2)) || (count_q == FULL - CW'(1) && !mem_valid));
  assign push_m    = mem_valid && mem_ready;
  assign push_a    = alu_valid && alu_ready;
  assign pop       = count_q != '0;
  assign wr_alu    = wr_q + PW'(push_m);

  always_comb begin
    rd_d    = rd_q + PW'(pop);
    wr_d    = wr_q + PW'(push_m) + PW'(push_a);
    count_d = count_q + CW'(push_m) + CW'(push_a) - CW'(pop);
    wre_d   = pop;
    a3_d    = pop ? addr_q[rd_q] : a3_q;
    wd3_d   = pop ? data_q[rd_q] : wd3_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      wre_q   <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      wre_q   <= wre_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
    end
  end

  // The load entry lands first, so a same-cycle ALU entry goes one slot behind it.
  always_ff @(posedge clk) begin
    if (push_m) begin
      addr_q[wr_q] <= mem_addr;
      data_q[wr_q] <= mem_data;
    end
    if (push_a) begin
      addr_q[wr_alu] <= alu_addr;
      data_q[wr_alu] <= alu_data;
    end
  end

  always_comb begin
    q_pending = wre_q && (a3_q == q_addr);
    for (int i = 0; i < DEPTH; i++)
      if (addr_q[i] == q_addr && {1'b0, PW'(PW'(i) - rd_q)} < count_q) q_pending = 1'b1;
  end

  assign wre   = wre_q;
  assign a3    = a3_q;
  assign wd3   = wd3_q;
  assign count = count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table, corner sequences and random traffic
// checked against a queue-based model of the write-back arbiter.
module tb_regfile_wb_arbiter;
  logic        clk, rst;
  logic        alu_valid, mem_valid, alu_ready, mem_ready, wre, q_pending;
  logic [3:0]  alu_addr, mem_addr, a3, q_addr;
  logic [15:0] alu_data, mem_data, wd3;
  logic [2:0]  count;

  regfile_wb_arbiter #(.DEPTH(4), .DW(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wre(wre), .a3(a3), .wd3(wd3), .q_addr(q_addr), .q_pending(q_pending), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] a; logic [15:0] d; } ent_t;
  typedef struct {
    bit av; logic [3:0] aa; logic [15:0] ad;
    bit mv; logic [3:0] ma; logic [15:0] md;
    logic [3:0] qa;
    bit ewre; logic [3:0] ea3; logic [15:0] ewd; int ecnt; bit eqp;
  } vec_t;

  ent_t        mq[$];
  vec_t        tbl[7];
  int          checks = 0, failures = 0, pulses = 0;
  bit          e_wre = 0, alu_low_seen = 0;
  logic [3:0]  e_a3 = '0;
  logic [15:0] e_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus, entered just after a falling edge; the model is a plain FIFO.
  task automatic step(input bit av, input logic [3:0] aa, input logic [15:0] ad,
                      input bit mv, input logic [3:0] ma, input logic [15:0] md,
                      input logic [3:0] qa);
    bit mr, ar, qp;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md; q_addr = qa;
    #1;
    mr = mq.size() < 4;
    ar = mq.size() <= 2 || (mq.size() == 3 && !mv);
    chk("mem_ready", mem_ready, mr);
    chk("alu_ready", alu_ready, ar);
    if (mq.size() == 3 && mv && av && !alu_ready) alu_low_seen = 1;
    e_wre = mq.size() > 0;
    if (e_wre) begin
      e_a3 = mq[0].a; e_wd = mq[0].d; void'(mq.pop_front());
    end
    if (mv && mr) mq.push_back({ma, md});
    if (av && ar) mq.push_back({aa, ad});
    @(posedge clk); @(negedge clk);
    qp = e_wre && e_a3 == qa;
    foreach (mq[i]) if (mq[i].a == qa) qp = 1;
    if (wre) pulses++;
    chk("wre", wre, e_wre);
    chk("a3", a3, e_a3);
    chk("wd3", wd3, e_wd);
    chk("count", count, mq.size());
    chk("q_pending", q_pending, qp);
  endtask

  task automatic idle(input int n, input logic [3:0] qa);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, qa);
  endtask

  initial begin
    rst = 1'b0; alu_valid = 0; mem_valid = 0;
    alu_addr = 0; alu_data = 0; mem_addr = 0; mem_data = 0; q_addr = 0;
    #2;
    chk("rst_wre", wre, 0);
    chk("rst_a3", a3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_count", count, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_alu_ready", alu_ready, 0);
    @(negedge clk);
    rst = 1'b1;

    tbl[0] = '{1, 4'd3, 16'h2222, 1, 4'd3, 16'h1111, 4'd3, 0, 4'd0, 16'h0000, 2, 1};
    tbl[1] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd3, 1, 4'd3, 16'h1111, 1, 1};
    tbl[2] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd3, 1, 4'd3, 16'h2222, 0, 1};
    tbl[3] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd3, 0, 4'd3, 16'h2222, 0, 0};
    tbl[4] = '{1, 4'd5, 16'h00AA, 0, 4'd0, 16'h0000, 4'd5, 0, 4'd3, 16'h2222, 1, 1};
    tbl[5] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd5, 1, 4'd5, 16'h00AA, 0, 1};
    tbl[6] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd5, 0, 4'd5, 16'h00AA, 0, 0};
    for (int r = 0; r < 7; r++) begin
      step(tbl[r].av, tbl[r].aa, tbl[r].ad, tbl[r].mv, tbl[r].ma, tbl[r].md, tbl[r].qa);
      chk($sformatf("tbl%0d_wre", r), wre, tbl[r].ewre);
      chk($sformatf("tbl%0d_a3", r), a3, tbl[r].ea3);
      chk($sformatf("tbl%0d_wd3", r), wd3, tbl[r].ewd);
      chk($sformatf("tbl%0d_count", r), count, tbl[r].ecnt);
      chk($sformatf("tbl%0d_qpend", r), q_pending, tbl[r].eqp);
    end

    // Saturation: both sources held every cycle while the drain runs.
    for (int k = 0; k < 6; k++) step(1, 4'(k), 16'h0A00 + 16'(k), 1, 4'(k + 8), 16'h0B00 + 16'(k), 4'(k));
    chk("full_alu_low", alu_low_seen, 1);
    idle(5, 0);

    // Pointer wrap: ten back-to-back single requests.
    pulses = 0;
    for (int k = 0; k < 10; k++) step(1, 4'(k), 16'(k), 0, 0, 0, 4'(k));
    idle(3, 9);
    chk("wrap_pulses", pulses, 10);

    // Backpressure: ALU data changes while blocked; only the accepted value is written.
    step(1, 4'd1, 16'hC001, 1, 4'd2, 16'hD001, 1);
    step(1, 4'd1, 16'hC002, 1, 4'd2, 16'hD002, 1);
    for (int k = 0; k < 3; k++) step(1, 4'd7, 16'hBEE0 + 16'(k), 1, 4'd6, 16'hE000 + 16'(k), 7);
    step(1, 4'd7, 16'hBEEF, 0, 0, 0, 7);
    idle(5, 7);

    // Reset in the middle of traffic.
    step(1, 4'd4, 16'h4444, 1, 4'd9, 16'h9999, 4);
    step(1, 4'd10, 16'hAAAA, 1, 4'd11, 16'hBBBB, 4);
    chk("pre_rst_count", count, 3);
    alu_valid = 0; mem_valid = 0;
    rst = 1'b0;
    #1;
    chk("midrst_wre", wre, 0);
    chk("midrst_count", count, 0);
    chk("midrst_mem_ready", mem_ready, 0);
    chk("midrst_alu_ready", alu_ready, 0);
    for (int a = 0; a < 16; a++) begin
      q_addr = 4'(a); #1;
      chk($sformatf("midrst_qpend%0d", a), q_pending, 0);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    mq.delete(); e_wre = 0; e_a3 = '0; e_wd = '0;
    idle(3, 4);

    for (int k = 0; k < 300; k++)
      step(1'($urandom), 4'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom), 4'($urandom_range(0, 15)), 16'($urandom), 4'($urandom_range(0, 15)));
    idle(6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
